// File: rtl/vx_rsp_tag_sched_pkg.sv
// Shared definitions for the response tag scheduler: FSM state encoding
// and the index-width helper used to size bank pointers and counters.
package vx_rsp_tag_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;

  // Bits needed to index n items; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/vx_rsp_tag_sched_rr_pick.sv
// Combinational circular priority finder.
// Ports:
//   req   - request vector, one bit per source
//   start - search begins at this index and wraps around
//   idx   - first requesting index at or after start
//   found - any request present
module vx_rsp_tag_sched_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int unsigned       pos;
    logic [IDX_W-1:0]  cand;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int unsigned off = N; off > 0; off--) begin
      pos  = (32'(start) + off - 32'd1) % N;
      cand = IDX_W'(pos);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_rsp_tag_sched.sv
// Response tag scheduler: picks a winning bank round-robin, gathers every
// bank holding a response with the same batch ID for up to BATCH_WAIT cycles,
// then offers the batch to the merge datapath.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   per_bank_rsp_valid/tag - per-bank pending responses
//   per_bank_rsp_ready     - bank response consumed this cycle
//   sel_valid/tag/bank_mask, sel_ready - batch handshake to the merge path
//   busy                   - scheduler is not idle
module vx_rsp_tag_sched
  import vx_rsp_tag_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS        = 4,
  parameter int unsigned CORE_TAG_WIDTH   = 8,
  parameter int unsigned CORE_TAG_ID_BITS = 4,
  parameter int unsigned BATCH_WAIT       = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_BANKS-1:0]                per_bank_rsp_valid,
  input  logic [NUM_BANKS*CORE_TAG_WIDTH-1:0] per_bank_rsp_tag,
  output logic [NUM_BANKS-1:0]                per_bank_rsp_ready,
  output logic                                sel_valid,
  output logic [CORE_TAG_WIDTH-1:0]           sel_tag,
  output logic [NUM_BANKS-1:0]                sel_bank_mask,
  input  logic                                sel_ready,
  output logic                                busy
);

  localparam int unsigned IDX_W = idx_width(NUM_BANKS);
  localparam int unsigned CNT_W = idx_width(BATCH_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((BATCH_WAIT > 0) ? BATCH_WAIT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_BANK = IDX_W'(NUM_BANKS - 1);

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          winner_q, winner_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [CORE_TAG_WIDTH-1:0] tag_q, tag_d;

  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_found;
  logic [CORE_TAG_WIDTH-1:0] pick_tag;
  logic [NUM_BANKS-1:0]      match;
  logic                      fire;

  vx_rsp_tag_sched_rr_pick #(
    .N     (NUM_BANKS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (per_bank_rsp_valid),
    .start (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Tag of the bank the picker selected.
  always_comb begin
    pick_tag = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_tag = per_bank_rsp_tag[i*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
      end
    end
  end

  // Banks whose batch ID equals the latched one; only meaningful once a winner is held.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      match[i] = (state_q != ST_IDLE) && per_bank_rsp_valid[i] &&
                 (per_bank_rsp_tag[i*CORE_TAG_WIDTH +: CORE_TAG_ID_BITS] ==
                  tag_q[CORE_TAG_ID_BITS-1:0]);
    end
  end

  // An empty batch is never offered, so it can never fire.
  assign sel_valid          = (state_q == ST_ISSUE) && (|match);
  assign sel_bank_mask      = (state_q == ST_ISSUE) ? match : '0;
  assign sel_tag            = tag_q;
  assign fire               = sel_valid && sel_ready;
  assign per_bank_rsp_ready = fire ? match : '0;
  assign busy               = (state_q != ST_IDLE);

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    wait_cnt_d = wait_cnt_q;
    tag_d      = tag_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          winner_d   = pick_idx;
          tag_d      = pick_tag;
          wait_cnt_d = '0;
          state_d    = (BATCH_WAIT == 0) ? ST_ISSUE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (match == '0) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if ((&match) || (wait_cnt_q == WAIT_LAST)) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (match == '0) begin
          state_d = ST_IDLE;
        end else if (fire) begin
          rr_ptr_d = (winner_q == LAST_BANK) ? '0 : winner_q + IDX_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      wait_cnt_q <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      wait_cnt_q <= wait_cnt_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_vx_rsp_tag_sched.sv
// Scoreboard bench for vx_rsp_tag_sched: expected batches are queued with the
// stimulus and compared when the scheduler fires. A second instance covers
// the BATCH_WAIT=0 configuration.
module tb_vx_rsp_tag_sched;

  typedef struct {
    logic [7:0] tag;
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  bank_v;
  logic [31:0] bank_tag;
  logic [3:0]  a_rdy;
  logic        a_sel_valid;
  logic [7:0]  a_sel_tag;
  logic [3:0]  a_sel_mask;
  logic        a_sel_ready;
  logic        a_busy;

  logic [3:0]  b_v;
  logic [31:0] b_tag;
  logic [3:0]  b_rdy;
  logic        b_sel_valid;
  logic [7:0]  b_sel_tag;
  logic [3:0]  b_sel_mask;
  logic        b_sel_ready;
  logic        b_busy;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fire = 0;
  int   cyc    = 0;
  int   t0     = 0;

  logic       s_valid, s_busy;
  logic [7:0] s_tag;
  logic [3:0] s_mask, s_rdy;
  logic       sb_valid, sb_busy;
  logic [7:0] sb_tag;
  logic [3:0] sb_mask, sb_rdy;

  vx_rsp_tag_sched #(
    .NUM_BANKS(4), .CORE_TAG_WIDTH(8), .CORE_TAG_ID_BITS(4), .BATCH_WAIT(2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .per_bank_rsp_valid (bank_v),
    .per_bank_rsp_tag   (bank_tag),
    .per_bank_rsp_ready (a_rdy),
    .sel_valid          (a_sel_valid),
    .sel_tag            (a_sel_tag),
    .sel_bank_mask      (a_sel_mask),
    .sel_ready          (a_sel_ready),
    .busy               (a_busy)
  );

  vx_rsp_tag_sched #(
    .NUM_BANKS(4), .CORE_TAG_WIDTH(8), .CORE_TAG_ID_BITS(4), .BATCH_WAIT(0)
  ) dut_nowait (
    .clk                (clk),
    .reset              (reset),
    .per_bank_rsp_valid (b_v),
    .per_bank_rsp_tag   (b_tag),
    .per_bank_rsp_ready (b_rdy),
    .sel_valid          (b_sel_valid),
    .sel_tag            (b_sel_tag),
    .sel_bank_mask      (b_sel_mask),
    .sel_ready          (b_sel_ready),
    .busy               (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
  endtask

  task automatic set_bank(input int i, input logic [7:0] tag);
    bank_v[i] = 1'b1;
    bank_tag[i*8 +: 8] = tag;
  endtask

  task automatic push(input logic [7:0] tag, input logic [3:0] mask, input int c);
    exp_t e;
    e.tag = tag; e.mask = mask; e.cyc = c;
    sb.push_back(e);
  endtask

  // One cycle: sample at the falling edge, score any fire, then let banks drop consumed responses.
  task automatic step();
    logic [3:0] clr;
    exp_t e;
    clr = '0;
    @(negedge clk);
    s_valid = a_sel_valid; s_busy = a_busy; s_tag = a_sel_tag;
    s_mask = a_sel_mask; s_rdy = a_rdy;
    sb_valid = b_sel_valid; sb_busy = b_busy; sb_tag = b_sel_tag;
    sb_mask = b_sel_mask; sb_rdy = b_rdy;
    if (a_sel_valid && a_sel_ready) begin
      n_fire++;
      clr = a_rdy;
      if (sb.size() == 0) begin
        check("unexpected_fire", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("fire_tag", 32'(a_sel_tag), 32'(e.tag));
        check("fire_mask", 32'(a_sel_mask), 32'(e.mask));
        check("fire_ready", 32'(a_rdy), 32'(e.mask));
        check("fire_cycle", 32'(cyc - t0), 32'(e.cyc));
      end
    end else begin
      check("ready_without_fire", 32'(a_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    bank_v = bank_v & ~clr;
  endtask

  task automatic drain(input int max_cyc);
    for (int k = 0; k < max_cyc && sb.size() != 0; k++) step();
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int fires0;
    reset = 1'b0;
    bank_v = '0; bank_tag = '0; a_sel_ready = 1'b0;
    b_v = '0; b_tag = '0; b_sel_ready = 1'b0;

    // Reset values
    step(); step();
    check("rst_sel_valid", 32'(s_valid), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_sel_tag", 32'(s_tag), 32'd0);
    check("rst_sel_mask", 32'(s_mask), 32'd0);
    check("rst_nowait_busy", 32'(sb_busy), 32'd0);
    reset = 1'b1;

    // Banks 0 and 2 share tag 0x13: partial batch, full wait
    a_sel_ready = 1'b1;
    t0 = cyc;
    set_bank(0, 8'h13); set_bank(2, 8'h13);
    push(8'h13, 4'b0101, 3);
    step();
    check("t1_c0_busy", 32'(s_busy), 32'd0);
    step();
    check("t1_c1_busy", 32'(s_busy), 32'd1);
    check("t1_c1_valid", 32'(s_valid), 32'd0);
    drain(20);
    step();
    check("t1_bubble_busy", 32'(s_busy), 32'd0);
    check("t1_bubble_valid", 32'(s_valid), 32'd0);
    step();

    // All four banks tag 0x05: full match ends the wait early
    t0 = cyc;
    for (int i = 0; i < 4; i++) set_bank(i, 8'h05);
    push(8'h05, 4'b1111, 2);
    drain(20);
    step(); step();

    // Two IDs, round-robin pointer now at bank 2
    t0 = cyc;
    set_bank(1, 8'h21); set_bank(3, 8'h22);
    push(8'h22, 4'b1000, 3);
    push(8'h21, 4'b0010, 7);
    drain(30);
    step(); step();

    // Back-pressure with a late matching bank and a non-matching bank waiting
    a_sel_ready = 1'b0;
    fires0 = n_fire;
    t0 = cyc;
    set_bank(0, 8'h37); set_bank(1, 8'h38);
    push(8'h37, 4'b0101, 8);
    push(8'h38, 4'b0010, 12);
    step(); step(); step();
    step();
    check("t4_c3_valid", 32'(s_valid), 32'd1);
    check("t4_c3_tag", 32'(s_tag), 32'h37);
    check("t4_c3_mask", 32'(s_mask), 32'b0001);
    set_bank(2, 8'h47);
    step();
    check("t4_c4_mask", 32'(s_mask), 32'b0101);
    step(); step(); step();
    check("t4_c7_valid", 32'(s_valid), 32'd1);
    check("t4_c7_tag", 32'(s_tag), 32'h37);
    a_sel_ready = 1'b1;
    drain(30);
    check("t4_fire_count", 32'(n_fire - fires0), 32'd2);
    step(); step();

    // Reset while a batch is held in ISSUE
    a_sel_ready = 1'b0;
    t0 = cyc;
    set_bank(0, 8'h99); set_bank(2, 8'h11);
    step(); step(); step(); step();
    check("t5_issue_valid", 32'(s_valid), 32'd1);
    check("t5_issue_tag", 32'(s_tag), 32'h11);
    check("t5_issue_mask", 32'(s_mask), 32'b0100);
    reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(a_sel_valid), 32'd0);
    check("t5_rst_busy", 32'(a_busy), 32'd0);
    check("t5_rst_ready", 32'(a_rdy), 32'd0);
    check("t5_rst_mask", 32'(a_sel_mask), 32'd0);
    a_sel_ready = 1'b1;
    step(); step();
    reset = 1'b1;
    t0 = cyc;
    push(8'h99, 4'b0001, 3);
    push(8'h11, 4'b0100, 7);
    drain(30);
    step(); step();

    // No-wait instance: straight from IDLE to ISSUE
    b_sel_ready = 1'b1;
    t0 = cyc;
    b_v = 4'b1000;
    b_tag[24 +: 8] = 8'h6A;
    step();
    check("nw_c0_valid", 32'(sb_valid), 32'd0);
    check("nw_c0_busy", 32'(sb_busy), 32'd0);
    step();
    check("nw_c1_valid", 32'(sb_valid), 32'd1);
    check("nw_c1_mask", 32'(sb_mask), 32'b1000);
    check("nw_c1_tag", 32'(sb_tag), 32'h6A);
    check("nw_c1_ready", 32'(sb_rdy), 32'b1000);
    b_v = '0;
    step();
    check("nw_c2_busy", 32'(sb_busy), 32'd0);
    check("nw_c2_valid", 32'(sb_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
